inperiph: RTL

INPERIPH -- requirements
Module: inperiph

---
 rtl/inperiph_pkg.sv | 59 +++++
 rtl/inperiph_fifo.sv | 79 +++++++
 rtl/inperiph.sv | 86 ++++++++
 3 files changed

// File: rtl/inperiph_pkg.sv
// Shared constants, register map and STATUS/DATA word builders for the
// memory-mapped input byte peripheral.
package inperiph_pkg;

  localparam int DEPTH_DEFAULT = 8;

  localparam logic [31:0] INPERIPH_BASE = 32'h0003_4568;
  localparam logic [31:0] OFF_DATA      = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS    = 32'h0000_0004;

  // Only this address bit distinguishes the two registers; the bus
  // interface unit already qualifies strobes against the window.
  localparam int ADDR_SEL_BIT = 2;

  localparam int STAT_LEVEL_LSB = 0;
  localparam int STAT_LEVEL_W   = 8;
  localparam int STAT_EMPTY_BIT = 8;
  localparam int STAT_FULL_BIT  = 9;
  localparam int STAT_CNT_LSB   = 16;
  localparam int STAT_CNT_W     = 16;

  localparam int DATA_EMPTY_BIT = 8;

  typedef enum logic {
    REG_DATA   = 1'b0,
    REG_STATUS = 1'b1
  } reg_sel_e;

  function automatic logic [31:0] status_word(
    input logic [STAT_LEVEL_W-1:0] level,
    input logic                    empty,
    input logic                    full,
    input logic [STAT_CNT_W-1:0]   pop_cnt
  );
    logic [31:0] w;
    w = 32'h0000_0000;
    w[STAT_LEVEL_LSB +: STAT_LEVEL_W] = level;
    w[STAT_EMPTY_BIT]                 = empty;
    w[STAT_FULL_BIT]                  = full;
    w[STAT_CNT_LSB +: STAT_CNT_W]     = pop_cnt;
    return w;
  endfunction

  function automatic logic [31:0] data_word(
    input logic       empty,
    input logic [7:0] head
  );
    logic [31:0] w;
    w = 32'h0000_0000;
    w[DATA_EMPTY_BIT] = empty;
    if (empty) begin
      w[7:0] = 8'h00;
    end else begin
      w[7:0] = head;
    end
    return w;
  endfunction

endpackage

// File: rtl/inperiph_fifo.sv
// Receive byte FIFO: storage, wrapping head/tail pointers and an explicit
// occupancy count from which full/empty are derived. Flush beats push/pop.
module inperiph_fifo
  import inperiph_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [7:0]    head_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [LW-1:0] level_r;
  logic [LW-1:0] level_nxt_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full  = (level_r == LW'(DEPTH));
  assign empty = (level_r == LW'(0));
  assign level = level_r;

  // A pop against an empty FIFO is dropped even when a push lands in the
  // same cycle, so the new byte is not consumed before it is visible.
  assign push_ok_s = push && !full && !flush;
  assign pop_ok_s  = pop && !empty && !flush;

  assign head_data = mem_r[head_r];

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointer and occupancy state; flush returns everything to the origin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      level_r <= '0;
    end else if (flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      level_r <= '0;
    end else begin
      if (push_ok_s) begin
        tail_r <= tail_r + AW'(1);
      end
      if (pop_ok_s) begin
        head_r <= head_r + AW'(1);
      end
      level_r <= level_nxt_s;
    end
  end

  // Byte storage is deliberately left unreset; level gates its visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[tail_r] <= push_data;
    end
  end

endmodule

// File: rtl/inperiph.sv
// CPU-facing input peripheral: decodes DATA/STATUS accesses, keeps the
// 16-bit pop counter and builds the combinational read data.
module inperiph
  import inperiph_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  input  logic        dre,
  output logic [31:0] drdata,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready
);

  localparam int LW = $clog2(DEPTH) + 1;

  reg_sel_e              sel_s;
  logic                  wr_s;
  logic                  pop_req_s;
  logic                  flush_s;
  logic                  push_req_s;
  logic                  pop_accept_s;
  logic [7:0]            head_data_s;
  logic [LW-1:0]         level_s;
  logic [STAT_LEVEL_W-1:0] level8_s;
  logic                  full_s;
  logic                  empty_s;
  logic [STAT_CNT_W-1:0] pop_cnt_r;
  logic                  unused_s;

  assign sel_s      = reg_sel_e'(daddr[ADDR_SEL_BIT]);
  assign wr_s       = |dwe;
  assign pop_req_s  = dre && (sel_s == REG_DATA);
  assign flush_s    = wr_s && (sel_s == REG_STATUS);

  // Held low while in reset so no byte is taken across the release edge.
  assign in_ready   = reset_n && !full_s;
  assign push_req_s = in_valid && in_ready;

  assign pop_accept_s = pop_req_s && !empty_s && !flush_s;
  assign level8_s     = STAT_LEVEL_W'(level_s);

  assign unused_s = ^{dwdata, daddr[31:ADDR_SEL_BIT+1], daddr[ADDR_SEL_BIT-1:0]};

  inperiph_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_req_s),
    .push_data (in_data),
    .pop       (pop_req_s),
    .flush     (flush_s),
    .head_data (head_data_s),
    .level     (level_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Pop counter survives flush and wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pop_cnt_r <= '0;
    end else if (pop_accept_s) begin
      pop_cnt_r <= pop_cnt_r + STAT_CNT_W'(1);
    end else begin
      pop_cnt_r <= pop_cnt_r;
    end
  end

  // Read mux; STATUS reads carry no side effects.
  always_comb begin
    drdata = 32'h0000_0000;
    case (sel_s)
      REG_DATA:   drdata = data_word(empty_s, head_data_s);
      REG_STATUS: drdata = status_word(level8_s, empty_s, full_s, pop_cnt_r);
      default:    drdata = 32'h0000_0000;
    endcase
  end

endmodule
